id_ex_control_stage: RTL and testbench

- Producer end of the ALU control interface in the 5-stage MIPS pipeline.
- Decodes the D-stage instruction into the 3-bit ALUControl code and the datapath control bits, then registers them into the ID/EX pipeline register.
- Contains load-use hazard detection, which stalls F/D and inserts a bubble into E.
- Branch-taken flush also inserts a bubble into E.

---
 rtl/mips_ctrl_pkg.sv | 55 +++++
 rtl/id_ex_control_stage_if.sv | 37 +++
 rtl/mips_ctrl_decoder.sv | 72 +++++++
 rtl/id_ex_control_stage.sv | 57 +++++
 tb/tb_id_ex_control_stage.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared control definitions for the MIPS pipeline: ALU operation codes,
// opcode/funct encodings and the E-stage control bundle.
package mips_ctrl_pkg;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLL = 3'b111;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLL = 6'b000000;

   typedef struct packed {
      logic [2:0] alu_control;
      logic       alu_src;
      logic       shamt_src;
      logic       reg_write;
      logic       mem_write;
      logic       mem_to_reg;
      logic       branch;
      logic       jump;
      logic       illegal;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] write_reg;
   } e_ctrl_t;

   // A bubble does nothing architecturally; ADD keeps the ALU on a legal code.
   localparam e_ctrl_t E_BUBBLE = '{
      alu_control: ALU_ADD,
      alu_src:     1'b0,
      shamt_src:   1'b0,
      reg_write:   1'b0,
      mem_write:   1'b0,
      mem_to_reg:  1'b0,
      branch:      1'b0,
      jump:        1'b0,
      illegal:     1'b0,
      rs:          5'd0,
      rt:          5'd0,
      write_reg:   5'd0
   };

endpackage

// File: rtl/id_ex_control_stage_if.sv
// Handshake between the decode/control stage and the rest of the pipeline:
// the D-stage instruction and flush request in, stalls and E-stage controls out.
interface id_ex_control_stage_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   logic [DATA_W-1:0] instr_d;
   logic              flush_e_in;
   logic              stall_f;
   logic              stall_d;
   logic [2:0]        alu_control_e;
   logic              alu_src_e;
   logic              shamt_src_e;
   logic              reg_write_e;
   logic              mem_write_e;
   logic              mem_to_reg_e;
   logic              branch_e;
   logic              jump_e;
   logic              illegal_e;
   logic [REG_AW-1:0] rs_e;
   logic [REG_AW-1:0] rt_e;
   logic [REG_AW-1:0] write_reg_e;

   modport master (
      input  instr_d, flush_e_in,
      output stall_f, stall_d, alu_control_e, alu_src_e, shamt_src_e,
             reg_write_e, mem_write_e, mem_to_reg_e, branch_e, jump_e,
             illegal_e, rs_e, rt_e, write_reg_e
   );

   modport slave (
      output instr_d, flush_e_in,
      input  stall_f, stall_d, alu_control_e, alu_src_e, shamt_src_e,
             reg_write_e, mem_write_e, mem_to_reg_e, branch_e, jump_e,
             illegal_e, rs_e, rt_e, write_reg_e
   );
endinterface

// File: rtl/mips_ctrl_decoder.sv
// Pure combinational opcode/funct decoder producing the E-stage control bundle.
// Shared with single-cycle models, so it holds no state.
module mips_ctrl_decoder
   import mips_ctrl_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] instr,
   output e_ctrl_t           ctrl
);

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       unused_shamt;

   assign opcode       = instr[31:26];
   assign funct        = instr[5:0];
   // shamt feeds the datapath directly; the decoder only selects it
   assign unused_shamt = ^instr[10:6];

   // Map opcode/funct to controls; anything unrecognised becomes an inert illegal op.
   always_comb begin
      ctrl           = E_BUBBLE;
      ctrl.rs        = instr[25:21];
      ctrl.rt        = instr[20:16];
      ctrl.write_reg = instr[20:16];
      case (opcode)
         OP_RTYPE: begin
            ctrl.write_reg = instr[15:11];
            ctrl.reg_write = 1'b1;
            case (funct)
               FN_ADD:  ctrl.alu_control = ALU_ADD;
               FN_SUB:  ctrl.alu_control = ALU_SUB;
               FN_AND:  ctrl.alu_control = ALU_AND;
               FN_OR:   ctrl.alu_control = ALU_OR;
               FN_SLL: begin
                  ctrl.alu_control = ALU_SLL;
                  ctrl.shamt_src   = 1'b1;
               end
               default: begin
                  ctrl.reg_write = 1'b0;
                  ctrl.illegal   = 1'b1;
               end
            endcase
         end
         OP_LW: begin
            ctrl.alu_src    = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         OP_SW: begin
            ctrl.alu_src   = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         OP_BEQ: begin
            ctrl.alu_control = ALU_SUB;
            ctrl.branch      = 1'b1;
         end
         OP_ADDI: begin
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         OP_J: begin
            ctrl.jump = 1'b1;
         end
         default: begin
            ctrl.illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/id_ex_control_stage.sv
// ID/EX control stage: decodes the D instruction, detects load-use hazards
// against the instruction currently in E, and registers controls into E.
module id_ex_control_stage
   import mips_ctrl_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   id_ex_control_stage_if.master bus
);

   e_ctrl_t dec;
   e_ctrl_t e_q;
   logic    hazard;

   mips_ctrl_decoder #(.DATA_W(DATA_W)) u_decoder (
      .instr (bus.instr_d),
      .ctrl  (dec)
   );

   // A load in E whose destination is a D source must hold F/D for one cycle.
   // Writes to $0 never create a dependency.
   always_comb begin
      hazard = e_q.mem_to_reg & e_q.reg_write & (e_q.rt != '0) &
               ((e_q.rt == bus.instr_d[21 +: REG_AW]) |
                (e_q.rt == bus.instr_d[16 +: REG_AW]));
   end

   // ID/EX register: bubble on stall or flush, otherwise take the decode.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         e_q <= E_BUBBLE;
      end else if (hazard | bus.flush_e_in) begin
         e_q <= E_BUBBLE;
      end else begin
         e_q <= dec;
      end
   end

   assign bus.stall_f       = hazard;
   assign bus.stall_d       = hazard;
   assign bus.alu_control_e = e_q.alu_control;
   assign bus.alu_src_e     = e_q.alu_src;
   assign bus.shamt_src_e   = e_q.shamt_src;
   assign bus.reg_write_e   = e_q.reg_write;
   assign bus.mem_write_e   = e_q.mem_write;
   assign bus.mem_to_reg_e  = e_q.mem_to_reg;
   assign bus.branch_e      = e_q.branch;
   assign bus.jump_e        = e_q.jump;
   assign bus.illegal_e     = e_q.illegal;
   assign bus.rs_e          = e_q.rs;
   assign bus.rt_e          = e_q.rt;
   assign bus.write_reg_e   = e_q.write_reg;

endmodule

// File: tb/tb_id_ex_control_stage.sv
// Bench for id_ex_control_stage: directed literal checks plus a randomized
// instruction stream compared every cycle against a behavioural model.
module tb_id_ex_control_stage;

   typedef struct packed {
      logic [2:0] alu;
      logic       alu_src;
      logic       shamt;
      logic       rw;
      logic       mw;
      logic       m2r;
      logic       br;
      logic       j;
      logic       ill;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] wr;
   } m_t;

   logic clk;
   logic rst_n;
   logic chk_en;
   int   n_checks;
   int   n_fail;
   m_t   exp_e;

   id_ex_control_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

   id_ex_control_stage #(.DATA_W(32), .REG_AW(5)) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic m_t bubble();
      m_t b;
      b = '0;
      b.alu = 3'b010;
      return b;
   endfunction

   // Instruction semantics from the ISA table.
   function automatic m_t model_decode(input logic [31:0] w);
      m_t m;
      logic [5:0] op;
      logic [5:0] fn;
      op = w[31:26];
      fn = w[5:0];
      m = bubble();
      m.rs = w[25:21];
      m.rt = w[20:16];
      m.wr = (op == 6'd0) ? w[15:11] : w[20:16];
      if (op == 6'd0) begin
         m.rw = 1'b1;
         if (fn == 6'h20)      m.alu = 3'b010;
         else if (fn == 6'h22) m.alu = 3'b110;
         else if (fn == 6'h24) m.alu = 3'b000;
         else if (fn == 6'h25) m.alu = 3'b001;
         else if (fn == 6'h00) begin m.alu = 3'b111; m.shamt = 1'b1; end
         else begin m.rw = 1'b0; m.ill = 1'b1; end
      end else if (op == 6'h23) begin
         m.alu_src = 1'b1; m.rw = 1'b1; m.m2r = 1'b1;
      end else if (op == 6'h2B) begin
         m.alu_src = 1'b1; m.mw = 1'b1;
      end else if (op == 6'h04) begin
         m.alu = 3'b110; m.br = 1'b1;
      end else if (op == 6'h08) begin
         m.alu_src = 1'b1; m.rw = 1'b1;
      end else if (op == 6'h02) begin
         m.j = 1'b1;
      end else begin
         m.ill = 1'b1;
      end
      return m;
   endfunction

   function automatic logic model_hazard(input m_t e, input logic [31:0] w);
      return e.m2r && e.rw && (e.rt != 5'd0) &&
             ((e.rt == w[25:21]) || (e.rt == w[20:16]));
   endfunction

   // Reference E-stage register.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         exp_e <= bubble();
      else if (model_hazard(exp_e, bus.instr_d) || bus.flush_e_in)
         exp_e <= bubble();
      else
         exp_e <= model_decode(bus.instr_d);
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         check("stall_f", 8'(bus.stall_f), 8'(model_hazard(exp_e, bus.instr_d)));
         check("stall_d", 8'(bus.stall_d), 8'(model_hazard(exp_e, bus.instr_d)));
         check("alu_control_e", 8'(bus.alu_control_e), 8'(exp_e.alu));
         check("alu_src_e", 8'(bus.alu_src_e), 8'(exp_e.alu_src));
         check("shamt_src_e", 8'(bus.shamt_src_e), 8'(exp_e.shamt));
         check("reg_write_e", 8'(bus.reg_write_e), 8'(exp_e.rw));
         check("mem_write_e", 8'(bus.mem_write_e), 8'(exp_e.mw));
         check("mem_to_reg_e", 8'(bus.mem_to_reg_e), 8'(exp_e.m2r));
         check("branch_e", 8'(bus.branch_e), 8'(exp_e.br));
         check("jump_e", 8'(bus.jump_e), 8'(exp_e.j));
         check("illegal_e", 8'(bus.illegal_e), 8'(exp_e.ill));
         check("rs_e", 8'(bus.rs_e), 8'(exp_e.rs));
         check("rt_e", 8'(bus.rt_e), 8'(exp_e.rt));
         check("write_reg_e", 8'(bus.write_reg_e), 8'(exp_e.wr));
      end
   end

   task automatic drive(input logic [31:0] w, input logic f);
      @(posedge clk);
      #1;
      bus.instr_d    = w;
      bus.flush_e_in = f;
      #1;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [4:0] rs, rt, rd, sh;
      logic [5:0] fns [5];
      logic [31:0] w;
      fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h00;
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 3));
      sh = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 11))
         0, 1, 2: w = {6'h00, rs, rt, rd, sh, fns[$urandom_range(0, 4)]};
         3, 4:    w = {6'h23, rs, rt, 16'($urandom)};
         5:       w = {6'h2B, rs, rt, 16'($urandom)};
         6:       w = {6'h04, rs, rt, 16'($urandom)};
         7:       w = {6'h08, rs, rt, 16'($urandom)};
         8:       w = {6'h02, 26'($urandom)};
         9:       w = {6'($urandom_range(9, 63)), rs, rt, 16'($urandom)};
         10:      w = {6'h00, rs, rt, rd, sh, 6'h3F};
         default: w = 32'h0;
      endcase
      return w;
   endfunction

   initial begin
      n_checks       = 0;
      n_fail         = 0;
      chk_en         = 1'b0;
      rst_n          = 1'b0;
      bus.instr_d    = 32'h0;
      bus.flush_e_in = 1'b0;
      #12;
      check("rst alu_control_e", 8'(bus.alu_control_e), 8'h02);
      check("rst reg_write_e", 8'(bus.reg_write_e), 8'h00);
      check("rst stall_d", 8'(bus.stall_d), 8'h00);
      check("rst write_reg_e", 8'(bus.write_reg_e), 8'h00);
      @(negedge clk);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      drive(32'h00221820, 1'b0);               // add $3,$1,$2
      drive(32'h00022140, 1'b0);               // sll $4,$2,5
      check("add alu", 8'(bus.alu_control_e), 8'h02);
      check("add reg_write", 8'(bus.reg_write_e), 8'h01);
      check("add write_reg", 8'(bus.write_reg_e), 8'h03);
      check("add stall_d", 8'(bus.stall_d), 8'h00);
      drive(32'h8C250000, 1'b0);               // lw $5,0($1)
      check("sll alu", 8'(bus.alu_control_e), 8'h07);
      check("sll shamt_src", 8'(bus.shamt_src_e), 8'h01);
      check("sll alu_src", 8'(bus.alu_src_e), 8'h00);
      check("sll write_reg", 8'(bus.write_reg_e), 8'h04);
      drive(32'h00A13020, 1'b0);               // add $6,$5,$1 -> load-use
      check("lu stall_f", 8'(bus.stall_f), 8'h01);
      check("lu stall_d", 8'(bus.stall_d), 8'h01);
      drive(32'h00A13020, 1'b0);               // held
      check("lu bubble reg_write", 8'(bus.reg_write_e), 8'h00);
      check("lu bubble alu", 8'(bus.alu_control_e), 8'h02);
      check("lu released stall", 8'(bus.stall_d), 8'h00);
      drive(32'h8C200000, 1'b0);               // lw $0,0($1)
      check("lu add write_reg", 8'(bus.write_reg_e), 8'h06);
      check("lu add reg_write", 8'(bus.reg_write_e), 8'h01);
      drive(32'h00003020, 1'b0);               // add $6,$0,$0
      check("lw $0 no stall", 8'(bus.stall_d), 8'h00);
      drive(32'h10220003, 1'b1);               // beq with flush
      drive(32'h10220003, 1'b0);
      check("flush bubble branch", 8'(bus.branch_e), 8'h00);
      check("flush bubble alu", 8'(bus.alu_control_e), 8'h02);
      drive(32'hFC000000, 1'b0);               // illegal opcode
      check("beq alu", 8'(bus.alu_control_e), 8'h06);
      check("beq branch", 8'(bus.branch_e), 8'h01);
      drive(32'h00000000, 1'b0);
      check("illegal flag", 8'(bus.illegal_e), 8'h01);
      check("illegal reg_write", 8'(bus.reg_write_e), 8'h00);
      check("illegal mem_write", 8'(bus.mem_write_e), 8'h00);

      drive(32'h8C250000, 1'b0);
      drive(32'h00A13020, 1'b0);
      check("pre-rst stall_d", 8'(bus.stall_d), 8'h01);
      rst_n = 1'b0;
      #1;
      check("mid-stall rst alu", 8'(bus.alu_control_e), 8'h02);
      check("mid-stall rst mem_to_reg", 8'(bus.mem_to_reg_e), 8'h00);
      check("mid-stall rst stall_d", 8'(bus.stall_d), 8'h00);
      check("mid-stall rst stall_f", 8'(bus.stall_f), 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 600; i++) begin
         drive(rand_instr(), ($urandom_range(0, 4) == 0));
      end
      drive(32'h0, 1'b0);
      @(negedge clk);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
